m_fetch: RTL and testbench
==========================

Name: m_fetch

Overview:
- Instruction-fetch unit for the multi-cycle RV32I core; producer end of the decoder's instruction interface.
- Owns the PC and issues one read at a time to instruction memory.
- Holds the returned word stable with a valid flag until the core accepts it.
- Takes PC redirects from the branch/jump path (Branch, PCsrc results) and discards stale fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_LAT_MAX, 15, max cycles WAIT tolerates before asserting fetch_timeout (4-bit counter).

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; equals PC while imem_req is high.
imem_gnt  input  1  memory accepts request this cycle when imem_req=1.
imem_rvalid  input  1  read data valid; exactly one per grant, earliest the cycle after grant.
imem_rdata  input  32  instruction word.
inst_valid  output  1  inst/w_PC hold a fetched instruction.
inst  output  32  instruction to decoder.
w_PC  output  32  PC of inst.
inst_ready  input  1  core consumes inst this cycle (meaningful only when inst_valid=1).
redirect_valid  input  1  load redirect_pc as the next PC.
redirect_pc  input  32  branch/jump target.
inst_count  output  32  count of instructions consumed (inst_valid and inst_ready, no redirect).
fetch_timeout  output  1  sticky; set when WAIT exceeds IMEM_LAT_MAX cycles.
fetch_misalign  output  1  misaligned-redirect flag (see Optional Feature).

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - pc=RESET_PC, state=IDLE, drop=0.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), w_PC=RESET_PC.
  - inst_count=0, fetch_timeout=0, fetch_misalign=0.
  - Reset mid-WAIT: the in-flight response is ignored. drop is not kept; memory must be quiet one cycle after reset, or the bench asserts no rvalid.
- IDLE: unconditional -> REQ next cycle.
- REQ:
  - imem_req=1, imem_addr=pc.
  - imem_gnt=1 -> WAIT; wait counter=0.
  - imem_req and imem_addr are combinational from state/pc, so the address is stable while waiting for grant.
- WAIT:
  - imem_req=0; counter increments, saturating.
  - imem_rvalid=1 and drop=0 -> inst<=imem_rdata, w_PC<=pc, inst_valid<=1, -> HOLD.
  - imem_rvalid=1 and drop=1 -> drop<=0, -> REQ; data discarded.
  - counter reaching IMEM_LAT_MAX -> fetch_timeout<=1. FSM keeps waiting.
- HOLD:
  - inst_valid=1; inst and w_PC stable.
  - inst_ready=1 -> pc<=pc+4 (mod 2^32, FFFF_FFFC wraps to 0), inst_valid<=0, inst_count+=1, -> REQ.
- Fetch latency: grant-to-inst_valid is rvalid latency + 1 cycle. With zero-wait memory (gnt in REQ, rvalid next cycle), minimum consume-to-consume is 3 cycles.
- Redirect (redirect_valid=1, any state except reset):
  - IDLE/REQ: pc<=redirect_pc.
    - If imem_gnt also =1: -> WAIT with drop<=1; the granted fetch is discarded.
    - Otherwise stay in REQ with the new address next cycle.
  - WAIT: pc<=redirect_pc, drop<=1. If rvalid arrives the same cycle, it is discarded and the FSM goes -> REQ.
  - HOLD: redirect beats inst_ready. inst_valid<=0, pc<=redirect_pc, -> REQ, inst_count unchanged.
  - Redirect pulses in consecutive cycles: last one wins.
- At most one outstanding memory request; no new request is issued before the rvalid of the prior grant.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 sets fetch_misalign<=1 (sticky until rst), loads pc, and parks the FSM in IDLE-hold. No further requests are issued, inst_valid=0.
- Undefined: redirect_pc[1:0] is forced to 2'b00 on load, and fetch_misalign is tied 0.

Decomposition:
- Package m_cpu_pkg:
  - fetch state enum (IDLE, REQ, WAIT, HOLD).
  - constants NOP_INST=32'h0000_0013, PC_STEP=4, default RESET_PC.
- Sub-module m_pc_next (combinational next-PC select: redirect / pc+4 / hold, with alignment handling). Instantiated once.

Test Plan:
- Reset, zero-wait memory returning 32'h0050_0093 at addr 0; inst_ready held 1 -> inst_valid at cycle 3 after rst falls, inst=32'h0050_0093, w_PC=0; next imem_addr=4; inst_count=1.
- imem_gnt withheld 5 cycles in REQ -> imem_addr stays 0 and imem_req stays 1 throughout; fetch completes normally afterwards.
- Redirect to 32'h0000_0100 in WAIT, rvalid same cycle with 32'hDEAD_BEEF -> data dropped, inst_valid stays 0, next imem_addr=0x100.
- HOLD with inst_ready=1 and redirect_valid=1 (target 0x40) in the same cycle -> inst_count unchanged, next imem_addr=0x40.
- pc=32'hFFFF_FFFC consumed -> next imem_addr=0; rvalid delayed 16 cycles -> fetch_timeout=1 and stays set until rst.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> fetch_misalign=1, imem_req stays 0. Without the macro -> imem_addr=0x100.

Source files
------------

// File: rtl/m_cpu_pkg.sv
// m_cpu_pkg: shared types and constants for the RV32I multi-cycle core front end.
//   - fetch FSM state encodings (IDLE, REQ, WAIT, HOLD)
//   - fetch_pkt_t: instruction word plus the PC it was fetched from
//   - NOP_INST, PC_STEP, DEFAULT_RESET_PC
package m_cpu_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned ST_W   = 2;
   localparam int unsigned WCNT_W = 4;

   // Fetch FSM encodings
   localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
   localparam logic [ST_W-1:0] ST_REQ  = 2'd1;
   localparam logic [ST_W-1:0] ST_WAIT = 2'd2;
   localparam logic [ST_W-1:0] ST_HOLD = 2'd3;

   localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Fetched instruction as handed to the decoder
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] word;
   } fetch_pkt_t;

endpackage

// File: rtl/m_pc_next.sv
// m_pc_next: combinational next-PC select for the fetch unit.
//   Priority: redirect > sequential advance (pc+4, wraps mod 2^32) > hold.
// Ports:
//   pc             in   current PC
//   advance        in   current instruction consumed, step to pc+4
//   redirect_valid in   load redirect target
//   redirect_pc    in   branch/jump target
//   pc_next        out  selected next PC
//   misalign       out  redirect target is not word aligned (trap build only)
// Build option FETCH_MISALIGN_TRAP_EN: when defined the target is loaded as-is
// and misaligned targets are flagged; otherwise the low two bits are cleared.
module m_pc_next
   import m_cpu_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic            advance,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc_next,
   output logic            misalign
);

   logic [XLEN-1:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign target   = redirect_pc;
   assign misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
   // Word-align the target; instructions are always 4-byte aligned.
   assign target   = redirect_pc & ~XLEN'(3);
   assign misalign = 1'b0;
`endif

   // Next-PC mux
   always_comb begin
      pc_next = pc;
      if (redirect_valid) begin
         pc_next = target;
      end else if (advance) begin
         pc_next = pc + PC_STEP;
      end
   end

endmodule

// File: rtl/m_fetch.sv
// m_fetch: instruction-fetch unit of the multi-cycle RV32I core.
//   Owns the PC, keeps at most one instruction-memory read outstanding,
//   and holds each returned word with inst_valid until the core accepts it.
//   Redirects reload the PC and discard any fetch already in flight.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_req/imem_addr  read request and address (combinational from state/pc)
//   imem_gnt            memory accepted the request this cycle
//   imem_rvalid/rdata   read response, one per grant
//   inst_valid/inst/w_PC  held instruction and its PC
//   inst_ready          core consumes inst this cycle
//   redirect_valid/pc   branch/jump redirect
//   inst_count          number of instructions consumed
//   fetch_timeout       sticky, a read waited more than IMEM_LAT_MAX cycles
//   fetch_misalign      sticky misaligned-redirect flag
// Build option FETCH_MISALIGN_TRAP_EN: misaligned redirects set fetch_misalign
// and park the FSM in IDLE until reset; without it the flag is constant 0.
module m_fetch
   import m_cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC     = DEFAULT_RESET_PC,
   parameter int unsigned     IMEM_LAT_MAX = 15
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] w_PC,
   input  logic            inst_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] inst_count,
   output logic            fetch_timeout,
   output logic            fetch_misalign
);

   localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(IMEM_LAT_MAX);
   localparam logic [WCNT_W-1:0] WCNT_SAT   = '1;

   logic [ST_W-1:0]   state;
   logic [ST_W-1:0]   state_nxt;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   pc_nxt;
   logic [XLEN-1:0]   pc_sel;
   logic              drop;
   logic              drop_nxt;
   logic [WCNT_W-1:0] wcnt;
   logic [WCNT_W-1:0] wcnt_nxt;
   fetch_pkt_t        held;
   fetch_pkt_t        held_nxt;
   logic              valid_nxt;
   logic [XLEN-1:0]   count_nxt;
   logic              timeout_nxt;
   logic              misalign_nxt;
   logic              advance_c;
   logic              misalign_c;

   // Memory request side follows state/pc directly so the address is
   // stable for as long as the grant is withheld.
   assign imem_req  = (state == ST_REQ);
   assign imem_addr = pc;
   assign inst      = held.word;
   assign w_PC      = held.pc;

   assign advance_c = (state == ST_HOLD) & inst_ready;

   m_pc_next u_pc_next (
      .pc             (pc),
      .advance        (advance_c),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc_next        (pc_sel),
      .misalign       (misalign_c)
   );

   // Next-state and datapath updates
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc_sel;
      drop_nxt     = drop;
      wcnt_nxt     = wcnt;
      held_nxt     = held;
      valid_nxt    = inst_valid;
      count_nxt    = inst_count;
      timeout_nxt  = fetch_timeout;
      misalign_nxt = fetch_misalign;

      case (state)
         ST_IDLE: begin
            // A raised misalign flag keeps the unit parked here.
            if (!fetch_misalign) begin
               state_nxt = ST_REQ;
            end
         end

         ST_REQ: begin
            if (imem_gnt) begin
               state_nxt = ST_WAIT;
               wcnt_nxt  = '0;
               // Grant coinciding with a redirect fetched the old PC.
               drop_nxt  = redirect_valid;
            end
         end

         ST_WAIT: begin
            if (wcnt != WCNT_SAT) begin
               wcnt_nxt = wcnt + WCNT_W'(1);
            end
            if (wcnt == WCNT_LIMIT) begin
               timeout_nxt = 1'b1;
            end
            if (imem_rvalid) begin
               drop_nxt = 1'b0;
               if (drop || redirect_valid) begin
                  state_nxt = ST_REQ;
               end else begin
                  held_nxt.pc   = pc;
                  held_nxt.word = imem_rdata;
                  valid_nxt     = 1'b1;
                  state_nxt     = ST_HOLD;
               end
            end else if (redirect_valid) begin
               drop_nxt = 1'b1;
            end
         end

         ST_HOLD: begin
            // Redirect takes precedence over consumption.
            if (redirect_valid) begin
               valid_nxt = 1'b0;
               state_nxt = ST_REQ;
            end else if (inst_ready) begin
               valid_nxt = 1'b0;
               count_nxt = inst_count + XLEN'(1);
               state_nxt = ST_REQ;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // Misaligned redirect (trap build): record it and park in IDLE.
      if (misalign_c) begin
         misalign_nxt = 1'b1;
         valid_nxt    = 1'b0;
         drop_nxt     = 1'b0;
         state_nxt    = ST_IDLE;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         pc             <= RESET_PC;
         drop           <= 1'b0;
         wcnt           <= '0;
         held.pc        <= RESET_PC;
         held.word      <= NOP_INST;
         inst_valid     <= 1'b0;
         inst_count     <= '0;
         fetch_timeout  <= 1'b0;
         fetch_misalign <= 1'b0;
      end else begin
         state          <= state_nxt;
         pc             <= pc_nxt;
         drop           <= drop_nxt;
         wcnt           <= wcnt_nxt;
         held           <= held_nxt;
         inst_valid     <= valid_nxt;
         inst_count     <= count_nxt;
         fetch_timeout  <= timeout_nxt;
         fetch_misalign <= misalign_nxt;
      end
   end

endmodule

// File: tb/tb_m_fetch.sv
// tb_m_fetch: self-checking bench for m_fetch.
//   A memory responder answers requests with configurable grant delay and
//   read latency; expected instruction streams are derived from PC arithmetic.
module tb_m_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] w_PC;
   logic        inst_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] inst_count;
   logic        fetch_timeout;
   logic        fetch_misalign;

   int tests = 0;
   int fails = 0;

   // Responder configuration
   bit          rand_mem = 1'b0;
   int          gdelay_cfg = 0;
   int          lat_cfg = 1;
   bit          ovr_en = 1'b0;
   logic [31:0] ovr_data = 32'h0;

   m_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .w_PC           (w_PC),
      .inst_ready     (inst_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_count     (inst_count),
      .fetch_timeout  (fetch_timeout),
      .fetch_misalign (fetch_misalign)
   );

   always #5 clk = ~clk;

   // Instruction memory contents
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   // Memory responder: drives just after each falling edge.
   initial begin : responder
      bit          pend;
      int          lat_cnt;
      int          gwait;
      logic [31:0] pend_addr;
      pend = 1'b0; lat_cnt = 0; gwait = 0; pend_addr = 32'h0;
      forever begin
         @(negedge clk); #1;
         imem_gnt    = 1'b0;
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (rst) begin
            pend  = 1'b0;
            gwait = rand_mem ? int'($urandom_range(0, 3)) : gdelay_cfg;
         end else if (pend) begin
            tests++;
            if (imem_req !== 1'b0) begin
               fails++;
               $display("FAIL one_outstanding: imem_req=%b while read of 0x%08h pending, required 0", imem_req, pend_addr);
            end
            if (lat_cnt <= 1) begin
               imem_rvalid = 1'b1;
               imem_rdata  = ovr_en ? ovr_data : mem_word(pend_addr);
               pend        = 1'b0;
            end else begin
               lat_cnt--;
            end
         end else if (imem_req === 1'b1) begin
            if (gwait == 0) begin
               imem_gnt  = 1'b1;
               pend      = 1'b1;
               pend_addr = imem_addr;
               lat_cnt   = rand_mem ? int'($urandom_range(1, 4)) : lat_cfg;
               gwait     = rand_mem ? int'($urandom_range(0, 3)) : gdelay_cfg;
            end else begin
               gwait--;
            end
         end
      end
   end

   // Two reset cycles; returns at the falling edge where rst drops.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", imem_req); end
      tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
      tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
      tests++; if (inst !== 32'h0000_0013) begin fails++; $display("FAIL rst_inst: got %h want 00000013", inst); end
      tests++; if (w_PC !== 32'h0) begin fails++; $display("FAIL rst_wpc: got %h want 0", w_PC); end
      tests++; if (inst_count !== 32'h0) begin fails++; $display("FAIL rst_count: got %0d want 0", inst_count); end
      tests++; if (fetch_timeout !== 1'b0) begin fails++; $display("FAIL rst_timeout: got %b want 0", fetch_timeout); end
      tests++; if (fetch_misalign !== 1'b0) begin fails++; $display("FAIL rst_misalign: got %b want 0", fetch_misalign); end
      rst = 1'b0;
   endtask

   task automatic test_zero_wait();
      int n;
      gdelay_cfg = 0; lat_cfg = 1; rand_mem = 1'b0;
      do_reset();
      inst_ready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (inst_valid !== 1'b1 && n < 10);
      tests++; if (n != 3) begin fails++; $display("FAIL zw_latency: inst_valid after %0d cycles, want 3", n); end
      tests++; if (inst !== 32'h0050_0093) begin fails++; $display("FAIL zw_inst: got %h want 00500093", inst); end
      tests++; if (w_PC !== 32'h0) begin fails++; $display("FAIL zw_wpc: got %h want 0", w_PC); end
      @(negedge clk);
      tests++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin fails++; $display("FAIL zw_next_addr: req=%b addr=%h want 1/4", imem_req, imem_addr); end
      tests++; if (inst_count !== 32'd1) begin fails++; $display("FAIL zw_count: got %0d want 1", inst_count); end
      repeat (2) @(negedge clk);
      tests++; if (inst_valid !== 1'b1 || w_PC !== 32'h4) begin fails++; $display("FAIL zw_back_to_back: valid=%b wpc=%h want 1/4", inst_valid, w_PC); end
      tests++; if (inst !== mem_word(32'h4)) begin fails++; $display("FAIL zw_inst2: got %h want %h", inst, mem_word(32'h4)); end
   endtask

   task automatic test_gnt_withheld();
      int n;
      gdelay_cfg = 5; lat_cfg = 1; rand_mem = 1'b0;
      do_reset();
      inst_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         tests++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            fails++; $display("FAIL gnt_hold_c%0d: req=%b addr=%h want 1/0", k, imem_req, imem_addr);
         end
      end
      n = 0;
      while (inst_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL gnt_complete: inst_valid=%b after bound, want 1", inst_valid); end
      tests++; if (inst !== mem_word(32'h0) || w_PC !== 32'h0) begin fails++; $display("FAIL gnt_data: inst=%h wpc=%h want %h/0", inst, w_PC, mem_word(32'h0)); end
      gdelay_cfg = 0;
   endtask

   task automatic test_redirect_wait();
      int n;
      gdelay_cfg = 0; lat_cfg = 1; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
      do_reset();
      inst_ready = 1'b1;
      @(negedge clk);
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rw_req: got %b want 1", imem_req); end
      @(negedge clk);
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rw_in_wait: req=%b want 0", imem_req); end
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
      @(negedge clk);
      redirect_valid = 1'b0; ovr_en = 1'b0;
      tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rw_dropped: inst_valid=%b inst=%h want 0", inst_valid, inst); end
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL rw_addr: req=%b addr=%h want 1/100", imem_req, imem_addr); end
      n = 0;
      while (inst_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      tests++; if (inst_valid !== 1'b1 || w_PC !== 32'h100 || inst !== mem_word(32'h100)) begin
         fails++; $display("FAIL rw_refetch: valid=%b wpc=%h inst=%h want 1/100/%h", inst_valid, w_PC, inst, mem_word(32'h100));
      end
   endtask

   task automatic test_hold_redirect();
      int n;
      gdelay_cfg = 0; lat_cfg = 1;
      do_reset();
      n = 0;
      while (inst_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      tests++; if (inst_valid !== 1'b1 || w_PC !== 32'h0) begin fails++; $display("FAIL hr_hold: valid=%b wpc=%h want 1/0", inst_valid, w_PC); end
      inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
      @(negedge clk);
      redirect_valid = 1'b0;
      tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL hr_valid: got %b want 0", inst_valid); end
      tests++; if (inst_count !== 32'd0) begin fails++; $display("FAIL hr_count: got %0d want 0", inst_count); end
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin fails++; $display("FAIL hr_addr: req=%b addr=%h want 1/40", imem_req, imem_addr); end
      n = 0;
      while (inst_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      tests++; if (w_PC !== 32'h40 || inst !== mem_word(32'h40)) begin fails++; $display("FAIL hr_target: wpc=%h inst=%h want 40/%h", w_PC, inst, mem_word(32'h40)); end
      @(negedge clk);
      tests++; if (inst_count !== 32'd1) begin fails++; $display("FAIL hr_count2: got %0d want 1", inst_count); end
   endtask

   task automatic test_wrap_timeout();
      int n;
      gdelay_cfg = 0; lat_cfg = 1;
      do_reset();
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0; lat_cfg = 15;
      n = 0;
      while (inst_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      tests++; if (inst_valid !== 1'b1 || w_PC !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wt_top: valid=%b wpc=%h want 1/fffffffc", inst_valid, w_PC); end
      tests++; if (fetch_timeout !== 1'b0) begin fails++; $display("FAIL wt_lat15: timeout=%b want 0", fetch_timeout); end
      lat_cfg = 16; inst_ready = 1'b1;
      @(negedge clk);
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL wt_wrap: req=%b addr=%h want 1/0", imem_req, imem_addr); end
      n = 0;
      while (inst_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      tests++; if (inst_valid !== 1'b1 || w_PC !== 32'h0) begin fails++; $display("FAIL wt_fetch0: valid=%b wpc=%h want 1/0", inst_valid, w_PC); end
      tests++; if (fetch_timeout !== 1'b1) begin fails++; $display("FAIL wt_lat16: timeout=%b want 1", fetch_timeout); end
      lat_cfg = 1;
      repeat (8) @(negedge clk);
      tests++; if (fetch_timeout !== 1'b1) begin fails++; $display("FAIL wt_sticky: timeout=%b want 1", fetch_timeout); end
      do_reset();
      tests++; if (fetch_timeout !== 1'b0) begin fails++; $display("FAIL wt_rst_clear: timeout=%b want 0", fetch_timeout); end
   endtask

   task automatic test_misalign();
      int n;
      gdelay_cfg = 0; lat_cfg = 1;
      do_reset();
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
      @(negedge clk);
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      tests++; if (fetch_misalign !== 1'b1) begin fails++; $display("FAIL ma_flag: got %b want 1", fetch_misalign); end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         tests++;
         if (imem_req !== 1'b0 || inst_valid !== 1'b0 || fetch_misalign !== 1'b1) begin
            fails++; $display("FAIL ma_parked_c%0d: req=%b valid=%b flag=%b want 0/0/1", k, imem_req, inst_valid, fetch_misalign);
         end
      end
`else
      n = 0;
      while (imem_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL ma_align: req=%b addr=%h want 1/100", imem_req, imem_addr); end
      tests++; if (fetch_misalign !== 1'b0) begin fails++; $display("FAIL ma_flag: got %b want 0", fetch_misalign); end
`endif
      do_reset();
      tests++; if (fetch_misalign !== 1'b0) begin fails++; $display("FAIL ma_rst_clear: got %b want 0", fetch_misalign); end
   endtask

   // Random ready/redirect traffic against a PC-sequence model.
   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] exp_cnt;
      logic [31:0] tgt;
      bit          rdy;
      bit          rdr;
      rand_mem = 1'b1;
      do_reset();
      exp_pc = 32'h0; exp_cnt = 32'h0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rdy = ($urandom_range(0, 3) != 0);
         rdr = ($urandom_range(0, 19) == 0);
         tgt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
         tgt = tgt & ~32'h3;
`endif
         if (inst_valid === 1'b1 && rdy && !rdr) begin
            tests++;
            if (w_PC !== exp_pc || inst !== mem_word(exp_pc) || inst_count !== exp_cnt) begin
               fails++;
               $display("FAIL rnd_consume: wpc=%h inst=%h cnt=%0d want %h/%h/%0d", w_PC, inst, inst_count, exp_pc, mem_word(exp_pc), exp_cnt);
            end
            exp_pc  = exp_pc + 32'd4;
            exp_cnt = exp_cnt + 32'd1;
         end
         if (rdr) exp_pc = tgt & ~32'h3;
         inst_ready = rdy; redirect_valid = rdr; redirect_pc = tgt;
      end
      inst_ready = 1'b0; redirect_valid = 1'b0;
      @(negedge clk);
      tests++; if (inst_count !== exp_cnt) begin fails++; $display("FAIL rnd_count: got %0d want %0d", inst_count, exp_cnt); end
      tests++; if (fetch_timeout !== 1'b0) begin fails++; $display("FAIL rnd_timeout: got %b want 0", fetch_timeout); end
      rand_mem = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_gnt_withheld();
      test_redirect_wait();
      test_hold_redirect();
      test_wrap_timeout();
      test_misalign();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
